// File: rtl/ysyx_23060208_lsu_pkg.sv
// ysyx_23060208_lsu_pkg: shared types and constants for the load/store unit.
package ysyx_23060208_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AWW,
        WR_B,
        RESP
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS      = 2'd2;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_H && lo[0]) || (size == SZ_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_if.sv
// ysyx_23060208_lsu_if: single-beat AXI4 channel bundle between the LSU and memory.
interface ysyx_23060208_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    parameter int ID_WIDTH   = 4
);
    logic                   awvalid;
    logic                   awready;
    logic [DATA_WIDTH-1:0]  awaddr;
    logic [ID_WIDTH-1:0]    awid;
    logic [7:0]             awlen;
    logic [2:0]             awsize;
    logic [1:0]             awburst;
    logic                   wvalid;
    logic                   wready;
    logic [BUS_WIDTH-1:0]   wdata;
    logic [BUS_WIDTH/8-1:0] wstrb;
    logic                   wlast;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic [ID_WIDTH-1:0]    bid;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_WIDTH-1:0]  araddr;
    logic [ID_WIDTH-1:0]    arid;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   rvalid;
    logic                   rready;
    logic [BUS_WIDTH-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic [ID_WIDTH-1:0]    rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );

endinterface

// File: rtl/ysyx_23060208_lsu_lane.sv
// ysyx_23060208_lsu_lane: byte-lane steering for stores and extraction/extension for loads.
// Purely combinational so the fetch/cache path can reuse it.
module ysyx_23060208_lsu_lane
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 64,
    localparam int OFF_W     = $clog2(BUS_WIDTH / 8),
    localparam int STRB_W    = BUS_WIDTH / 8
) (
    input  logic [OFF_W-1:0]      off,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [BUS_WIDTH-1:0]  bus_wdata,
    output logic [STRB_W-1:0]     bus_wstrb,
    input  logic [BUS_WIDTH-1:0]  bus_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);
    logic [DATA_WIDTH-1:0] raw;
    logic [DATA_WIDTH-1:0] mask;
    logic                  neg;

    assign bus_wdata = {(BUS_WIDTH / DATA_WIDTH){st_data}} << {off, 3'b000};
    assign bus_wstrb = (size == SZ_B ? STRB_W'(4'h1) : size == SZ_H ? STRB_W'(4'h3) : STRB_W'(4'hF)) << off;

    // Extension is done by masking the kept bytes and filling the rest with the sign.
    assign raw     = DATA_WIDTH'(bus_rdata >> {off, 3'b000});
    assign mask    = size == SZ_B ? DATA_WIDTH'(8'hFF) : size == SZ_H ? DATA_WIDTH'(16'hFFFF) : '1;
    assign neg     = sign_ext && (size == SZ_B ? raw[7] : size == SZ_H ? raw[15] : raw[DATA_WIDTH-1]);
    assign ld_data = (raw & mask) | (neg ? ~mask : '0);

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// ysyx_23060208_lsu: single-outstanding load/store unit bridging the execute stage to AXI4.
// One request in, one single-beat AXI transaction out, one registered response back.
module ysyx_23060208_lsu
    import ysyx_23060208_lsu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BUS_WIDTH  = 64,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [DATA_WIDTH-1:0] MMIO_BASE  = 32'h1000_0000,
    parameter logic [DATA_WIDTH-1:0] MMIO_MASK  = 32'hFFFF_F000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [4:0]            rsp_rd,
    output logic [1:0]            rsp_err,
    ysyx_23060208_lsu_if.master   axi
);
    localparam int         OFF_W     = $clog2(BUS_WIDTH / 8);
    localparam logic [2:0] FULL_SIZE = 3'($clog2(DATA_WIDTH / 8));

    lsu_state_t             state;
    logic [1:0]             st_size;
    logic                   st_signed;
    logic [OFF_W-1:0]       st_off;
    logic [ID_WIDTH-1:0]    id_cnt;
    logic                   aw_done;
    logic                   w_done;
    logic                   aw_fin;
    logic                   w_fin;
    logic                   rd_hit;
    logic                   b_hit;
    logic [2:0]             size_field;
    logic [OFF_W-1:0]       lane_off;
    logic [1:0]             lane_size;
    logic [BUS_WIDTH-1:0]   lane_wdata;
    logic [BUS_WIDTH/8-1:0] lane_wstrb;
    logic [DATA_WIDTH-1:0]  ld_data;
    logic                   unused_rlast;

    assign unused_rlast = axi.rlast;
    assign axi.awlen    = '0;
    assign axi.arlen    = '0;
    assign axi.awburst  = BURST_INCR;
    assign axi.arburst  = BURST_INCR;
    assign axi.wlast    = axi.wvalid;

    // The lane steers the incoming store while idle and the held load afterwards.
    assign lane_off   = state == IDLE ? req_addr[OFF_W-1:0] : st_off;
    assign lane_size  = state == IDLE ? req_size : st_size;
    assign size_field = (req_addr & MMIO_MASK) == MMIO_BASE ? {1'b0, req_size} : FULL_SIZE;
    assign aw_fin     = aw_done || (axi.awvalid && axi.awready);
    assign w_fin      = w_done || (axi.wvalid && axi.wready);
    assign rd_hit     = axi.rvalid && axi.rid == axi.arid;
    assign b_hit      = axi.bvalid && axi.bid == axi.awid;

    ysyx_23060208_lsu_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUS_WIDTH  (BUS_WIDTH)
    ) u_lane (
        .off       (lane_off),
        .size      (lane_size),
        .sign_ext  (st_signed),
        .st_data   (req_wdata),
        .bus_wdata (lane_wdata),
        .bus_wstrb (lane_wstrb),
        .bus_rdata (axi.rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            st_size     <= '0;
            st_signed   <= 1'b0;
            st_off      <= '0;
            id_cnt      <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_rd      <= '0;
            rsp_err     <= '0;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.awid    <= '0;
            axi.awsize  <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.arid    <= '0;
            axi.arsize  <= '0;
            axi.rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    st_size   <= req_size;
                    st_signed <= req_signed;
                    st_off    <= req_addr[OFF_W-1:0];
                    rsp_rd    <= req_rd;
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ERR_MISALIGN;
                        rsp_rdata <= '0;
                    end else if (req_store) begin
                        state       <= WR_AWW;
                        id_cnt      <= id_cnt + ID_WIDTH'(1);
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        axi.awvalid <= 1'b1;
                        axi.awaddr  <= req_addr;
                        axi.awid    <= id_cnt;
                        axi.awsize  <= size_field;
                        axi.wvalid  <= 1'b1;
                        axi.wdata   <= lane_wdata;
                        axi.wstrb   <= lane_wstrb;
                    end else begin
                        state       <= RD_AR;
                        id_cnt      <= id_cnt + ID_WIDTH'(1);
                        axi.arvalid <= 1'b1;
                        axi.araddr  <= req_addr;
                        axi.arid    <= id_cnt;
                        axi.arsize  <= size_field;
                    end
                end
                RD_AR: if (axi.arready) begin
                    state       <= RD_R;
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                end
                // Beats carrying a foreign rid are accepted and silently dropped.
                RD_R: if (rd_hit) begin
                    state      <= RESP;
                    axi.rready <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= axi.rresp >= RESP_SLVERR ? ERR_BUS : ERR_OK;
                    rsp_rdata  <= axi.rresp >= RESP_SLVERR ? '0 : ld_data;
                end
                WR_AWW: begin
                    if (axi.awvalid && axi.awready) begin
                        axi.awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (axi.wvalid && axi.wready) begin
                        axi.wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state      <= WR_B;
                        axi.bready <= 1'b1;
                    end
                end
                WR_B: if (b_hit) begin
                    state      <= RESP;
                    axi.bready <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= axi.bresp >= RESP_SLVERR ? ERR_BUS : ERR_OK;
                    rsp_rdata  <= '0;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// tb_ysyx_23060208_lsu: directed vectors against a scripted AXI slave, hand-computed expectations.
module tb_ysyx_23060208_lsu;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_err;
    logic [3:0]  exp_id;
    int          vectors;
    int          miscompares;

    ysyx_23060208_lsu_if #(.DATA_WIDTH(32), .BUS_WIDTH(64), .ID_WIDTH(4)) axi ();

    ysyx_23060208_lsu #(
        .DATA_WIDTH (32),
        .BUS_WIDTH  (64),
        .ID_WIDTH   (4),
        .MMIO_BASE  (32'h1000_0000),
        .MMIO_MASK  (32'hFFFF_F000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
        .axi        (axi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_req(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        chk("req_ready idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        req_rd     = rd;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_err,
                            input logic [4:0] rd, input int hold, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, " rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_d);
        chk({tag, " rsp_err"}, rsp_err, exp_err);
        chk({tag, " rsp_rd"}, rsp_rd, rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, " hold"}, {rsp_valid, req_ready, rsp_err, rsp_rd, rsp_rdata}, {1'b1, 1'b0, exp_err, rd, exp_d});
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({tag, " released"}, {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic rd_txn(input string tag, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [63:0] d, input logic [1:0] resp, input logic bad_rid, input int hold,
                          input logic [31:0] exp_d, input logic [1:0] exp_err, input logic [2:0] exp_sz,
                          input logic [4:0] rd);
        int lat;
        send_req(1'b0, sz, sg, a, 32'h0, rd);
        chk({tag, " arvalid"}, {axi.arvalid, axi.awvalid}, 2'b10);
        chk({tag, " araddr"}, axi.araddr, a);
        chk({tag, " arsize"}, axi.arsize, exp_sz);
        chk({tag, " arid"}, axi.arid, exp_id);
        chk({tag, " arlen/burst"}, {axi.arlen, axi.arburst}, {8'h00, 2'b01});
        axi.arready = 1'b1;
        @(negedge clock);
        axi.arready = 1'b0;
        chk({tag, " ar done"}, {axi.arvalid, axi.rready}, 2'b01);
        axi.rlast = 1'b1;
        if (bad_rid) begin
            axi.rvalid = 1'b1;
            axi.rid    = exp_id + 4'd1;
            axi.rdata  = ~d;
            axi.rresp  = 2'b00;
            @(negedge clock);
            chk({tag, " rid skip"}, {rsp_valid, axi.rready}, 2'b01);
        end
        axi.rvalid = 1'b1;
        axi.rid    = exp_id;
        axi.rdata  = d;
        axi.rresp  = resp;
        @(negedge clock);
        axi.rvalid = 1'b0;
        exp_id = exp_id + 4'd1;
        wait_rsp(tag, exp_d, exp_err, rd, hold, lat);
        chk({tag, " latency"}, lat, 0);
    endtask

    task automatic wr_txn(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int aw_dly, input int w_dly, input logic bad_bid, input logic [1:0] resp,
                          input logic [63:0] exp_wd, input logic [7:0] exp_strb, input logic [2:0] exp_sz,
                          input logic [1:0] exp_err, input logic [4:0] rd);
        int aw_cnt;
        int w_cnt;
        int lat;
        send_req(1'b1, sz, 1'b0, a, d, rd);
        chk({tag, " aw/w valid"}, {axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid}, 4'b1110);
        chk({tag, " awaddr"}, axi.awaddr, a);
        chk({tag, " awsize"}, axi.awsize, exp_sz);
        chk({tag, " awid"}, axi.awid, exp_id);
        chk({tag, " wdata"}, axi.wdata, exp_wd);
        chk({tag, " wstrb"}, axi.wstrb, exp_strb);
        aw_cnt = 0;
        w_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            axi.awready = c >= aw_dly;
            axi.wready  = c >= w_dly;
            if (axi.awvalid && axi.awready) aw_cnt++;
            if (axi.wvalid && axi.wready) w_cnt++;
            @(negedge clock);
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        chk({tag, " aw beats"}, aw_cnt, 1);
        chk({tag, " w beats"}, w_cnt, 1);
        chk({tag, " bready"}, {axi.bready, axi.awvalid, axi.wvalid}, 3'b100);
        axi.bvalid = 1'b1;
        if (bad_bid) begin
            axi.bid   = exp_id + 4'd1;
            axi.bresp = 2'b00;
            @(negedge clock);
            chk({tag, " bid skip"}, {rsp_valid, axi.bready}, 2'b01);
        end
        axi.bid   = exp_id;
        axi.bresp = resp;
        @(negedge clock);
        axi.bvalid = 1'b0;
        exp_id = exp_id + 4'd1;
        wait_rsp(tag, 32'h0, exp_err, rd, 0, lat);
        chk({tag, " latency"}, lat, 0);
    endtask

    task automatic mis_txn(input string tag, input logic [1:0] sz, input logic [31:0] a, input logic [4:0] rd);
        int lat;
        send_req(1'b0, sz, 1'b1, a, 32'h0, rd);
        chk({tag, " no bus"}, {axi.arvalid, axi.awvalid, axi.wvalid}, 3'b000);
        wait_rsp(tag, 32'h0, 2'd1, rd, 0, lat);
        chk({tag, " within two cycles"}, lat <= 1, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_id      = 4'd0;
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_store   = 1'b0;
        req_size    = 2'd0;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_rd      = 5'd0;
        rsp_ready   = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'd0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 64'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rid     = 4'd0;
        @(negedge clock);
        chk("reset handshake", {req_ready, rsp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 7'b1000000);
        chk("reset data", {axi.awaddr, axi.araddr, axi.wstrb, rsp_rdata, rsp_err, rsp_rd}, 111'h0);
        chk("reset wdata", axi.wdata, 64'h0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        rd_txn("lh_s", 2'd1, 1'b1, 32'h8000_0006, 64'h8001_5566_7788_99AA, 2'b00, 1'b0, 0, 32'hFFFF_8001, 2'd0, 3'd2, 5'd1);
        rd_txn("lh_u", 2'd1, 1'b0, 32'h8000_0006, 64'h8001_5566_7788_99AA, 2'b00, 1'b0, 0, 32'h0000_8001, 2'd0, 3'd2, 5'd2);
        rd_txn("lb_pos", 2'd0, 1'b1, 32'h8000_0003, 64'h0123_4567_7FAA_BBCC, 2'b00, 1'b0, 0, 32'h0000_007F, 2'd0, 3'd2, 5'd3);
        rd_txn("lb_neg_rid", 2'd0, 1'b1, 32'h8000_0007, 64'hF023_4567_7FAA_BBCC, 2'b00, 1'b1, 0, 32'hFFFF_FFF0, 2'd0, 3'd2, 5'd4);
        rd_txn("lw_hold", 2'd2, 1'b0, 32'h8000_0004, 64'hCAFE_BABE_1234_5678, 2'b00, 1'b0, 5, 32'hCAFE_BABE, 2'd0, 3'd2, 5'd5);
        rd_txn("lw_slverr", 2'd2, 1'b0, 32'h8000_0000, 64'h1111_2222_3333_4444, 2'b10, 1'b0, 0, 32'h0, 2'd2, 3'd2, 5'd6);
        rd_txn("lbu_mmio", 2'd0, 1'b0, 32'h1000_0002, 64'h0000_0000_00C3_0000, 2'b00, 1'b0, 0, 32'h0000_00C3, 2'd0, 3'd0, 5'd7);

        mis_txn("lw_mis", 2'd2, 32'h8000_0002, 5'd20);
        mis_txn("lh_mis", 2'd1, 32'h8000_0001, 5'd21);

        wr_txn("sb_w_first", 2'd0, 32'h8000_0005, 32'h0000_00AB, 3, 0, 1'b0, 2'b00, 64'h0000_AB00_0000_0000, 8'h20, 3'd2, 2'd0, 5'd8);
        wr_txn("sh_aw_first", 2'd1, 32'h8000_0004, 32'h0000_1234, 0, 3, 1'b0, 2'b00, 64'h0000_1234_0000_0000, 8'h30, 3'd2, 2'd0, 5'd9);
        wr_txn("sw_mmio_bid", 2'd2, 32'h1000_0000, 32'hDEAD_BEEF, 0, 0, 1'b1, 2'b00, 64'hDEAD_BEEF_DEAD_BEEF, 8'h0F, 3'd2, 2'd0, 5'd10);
        wr_txn("sb_mmio", 2'd0, 32'h1000_0003, 32'h0000_005A, 1, 1, 1'b0, 2'b00, 64'h5A00_0000_5A00_0000, 8'h08, 3'd0, 2'd0, 5'd11);
        wr_txn("sw_slverr", 2'd2, 32'h8000_0008, 32'h1122_3344, 2, 1, 1'b0, 2'b10, 64'h1122_3344_1122_3344, 8'h0F, 3'd2, 2'd2, 5'd12);

        send_req(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 5'd13);
        axi.arready = 1'b1;
        @(negedge clock);
        axi.arready = 1'b0;
        chk("pre-reset rready", axi.rready, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async reset handshake", {req_ready, rsp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 7'b1000000);
        chk("async reset addr", axi.araddr, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        exp_id = 4'd0;
        @(negedge clock);
        rd_txn("post_reset", 2'd2, 1'b0, 32'h8000_0000, 64'h0000_0000_AAAA_5555, 2'b00, 1'b0, 0, 32'hAAAA_5555, 2'd0, 3'd2, 5'd14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
